// File: rtl/tcdm_bank_rr_arbiter_pkg.sv
// Shared types and sizing for the TCDM bank round-robin arbiter.
// Widths of the response struct are fixed here so every file agrees on them.
package tcdm_arb_pkg;

  localparam int unsigned NumReq           = 4;
  localparam int unsigned AddrWidth        = 10;
  localparam int unsigned DataWidth        = 32;
  localparam int unsigned MetaWidth        = 16;
  localparam int unsigned DefaultRespDepth = 2;
  localparam int unsigned BeWidth          = DataWidth / 8;
  localparam int unsigned SelWidth         = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PerfCntWidth     = 32;

  typedef logic [SelWidth-1:0] sel_req_t;

  typedef struct packed {
    sel_req_t               sel;
    logic [MetaWidth-1:0]   meta;
    logic [DataWidth-1:0]   rdata;
  } arb_resp_t;

  // Cyclic successor of a requester index, used to advance the round-robin pointer.
  function automatic sel_req_t next_rr(sel_req_t idx);
    return (idx == sel_req_t'(NumReq - 1)) ? '0 : sel_req_t'(idx + 1'b1);
  endfunction

endpackage

// File: rtl/tcdm_bank_rr_arbiter_if.sv
// Request, bank, response and counter signals of the arbiter bundled as one interface.
// The arbiter uses the slave modport; requesters, bank model and consumer use master.
interface tcdm_bank_rr_arbiter_if;
  import tcdm_arb_pkg::*;

  logic [NumReq-1:0]                  req_valid_i;
  logic [NumReq-1:0]                  req_ready_o;
  logic [NumReq-1:0][AddrWidth-1:0]   req_addr_i;
  logic [NumReq-1:0]                  req_write_i;
  logic [NumReq-1:0][DataWidth-1:0]   req_wdata_i;
  logic [NumReq-1:0][BeWidth-1:0]     req_be_i;
  logic [NumReq-1:0][MetaWidth-1:0]   req_meta_i;

  logic                               bank_req_o;
  logic                               bank_we_o;
  logic [AddrWidth-1:0]               bank_addr_o;
  logic [DataWidth-1:0]               bank_wdata_o;
  logic [BeWidth-1:0]                 bank_be_o;
  logic [DataWidth-1:0]               bank_rdata_i;

  logic                               resp_valid_o;
  logic                               resp_ready_i;
  sel_req_t                           resp_sel_o;
  logic [MetaWidth-1:0]               resp_meta_o;
  logic [DataWidth-1:0]               resp_rdata_o;

  logic [PerfCntWidth-1:0]            grant_cnt_o;
  logic [PerfCntWidth-1:0]            conflict_cnt_o;
  logic [PerfCntWidth-1:0]            stall_cnt_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_be_i, req_meta_i,
    output req_ready_o,
    output bank_req_o, bank_we_o, bank_addr_o, bank_wdata_o, bank_be_o,
    input  bank_rdata_i,
    output resp_valid_o, resp_sel_o, resp_meta_o, resp_rdata_o,
    input  resp_ready_i,
    output grant_cnt_o, conflict_cnt_o, stall_cnt_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_be_i, req_meta_i,
    input  req_ready_o,
    input  bank_req_o, bank_we_o, bank_addr_o, bank_wdata_o, bank_be_o,
    output bank_rdata_i,
    input  resp_valid_o, resp_sel_o, resp_meta_o, resp_rdata_o,
    output resp_ready_i,
    input  grant_cnt_o, conflict_cnt_o, stall_cnt_o
  );

endinterface

// File: rtl/tcdm_bank_rr_arbiter_resp_fifo.sv
// Fall-through response FIFO: a push into an empty FIFO is visible on the output in the
// same cycle, and push/pop may coincide at any occupancy (including empty and full).
module tcdm_arb_resp_fifo
  import tcdm_arb_pkg::*;
#(
  parameter  int unsigned Depth    = 2,
  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned OccWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  arb_resp_t           data_i,
  output logic                valid_o,
  input  logic                pop_i,
  output arb_resp_t           data_o,
  output logic [OccWidth-1:0] occ_o
);

  arb_resp_t             mem_q [Depth];
  logic [PtrWidth-1:0]   wptr_q, wptr_d;
  logic [PtrWidth-1:0]   rptr_q, rptr_d;
  logic [OccWidth-1:0]   occ_q, occ_d;
  logic                  empty;
  logic                  bypass;
  logic                  doWrite;
  logic                  doRead;

  // An empty FIFO that is pushed and popped together passes the entry straight through.
  assign empty   = (occ_q == '0);
  assign bypass  = empty && push_i && pop_i;
  assign doWrite = push_i && !bypass;
  assign doRead  = pop_i && !empty;

  assign valid_o = !empty || push_i;
  assign data_o  = !empty ? mem_q[rptr_q] : (push_i ? data_i : '0);
  assign occ_o   = occ_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q + OccWidth'(doWrite) - OccWidth'(doRead);
    if (doWrite) wptr_d = (wptr_q == PtrWidth'(Depth - 1)) ? '0 : wptr_q + 1'b1;
    if (doRead)  rptr_d = (rptr_q == PtrWidth'(Depth - 1)) ? '0 : rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      if (doWrite) mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/tcdm_bank_rr_arbiter.sv
// Round-robin arbiter sharing one single-ported TCDM bank, with credit-protected response FIFO.
// Optional saturating performance counters are built when TCDM_ARB_PERF_CNT_EN is defined.
module tcdm_bank_rr_arbiter
  import tcdm_arb_pkg::*;
#(
  parameter  int unsigned RespDepth = DefaultRespDepth,
  localparam int unsigned OccWidth  = $clog2(RespDepth + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  tcdm_bank_rr_arbiter_if.slave  bus
);

  sel_req_t              rr_q, rr_d;
  sel_req_t              winner;
  sel_req_t              cand;
  logic                  found;
  logic                  arbEn;
  logic                  grant;
  logic                  pop;
  logic                  inflight_q;
  sel_req_t              sel_q;
  logic [MetaWidth-1:0]  meta_q;
  logic                  write_q;
  logic [OccWidth-1:0]   occ;
  arb_resp_t             pushData;
  arb_resp_t             respData;

  // The bank cannot stall, so a grant needs a response slot that is free now or freed by a pop.
  assign pop   = bus.resp_valid_o && bus.resp_ready_i;
  assign arbEn = ((32'(occ) + 32'(inflight_q)) < RespDepth) || pop;
  assign grant = found && arbEn;

  always_comb begin
    winner = rr_q;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = sel_req_t'((32'(rr_q) + k) % NumReq);
      if (!found && bus.req_valid_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    bus.req_ready_o  = '0;
    bus.bank_req_o   = 1'b0;
    bus.bank_we_o    = 1'b0;
    bus.bank_addr_o  = '0;
    bus.bank_wdata_o = '0;
    bus.bank_be_o    = '0;
    rr_d             = rr_q;
    if (grant) begin
      bus.req_ready_o[winner] = 1'b1;
      bus.bank_req_o          = 1'b1;
      bus.bank_we_o           = bus.req_write_i[winner];
      bus.bank_addr_o         = bus.req_addr_i[winner];
      bus.bank_wdata_o        = bus.req_wdata_i[winner];
      bus.bank_be_o           = bus.req_be_i[winner];
      rr_d                    = next_rr(winner);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      inflight_q <= 1'b0;
      sel_q      <= '0;
      meta_q     <= '0;
      write_q    <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      inflight_q <= grant;
      if (grant) begin
        sel_q   <= winner;
        meta_q  <= bus.req_meta_i[winner];
        write_q <= bus.req_write_i[winner];
      end
    end
  end

  // Bank read data is only valid the cycle after the access; writes return zero data.
  assign pushData.sel   = sel_q;
  assign pushData.meta  = meta_q;
  assign pushData.rdata = write_q ? '0 : bus.bank_rdata_i;

  tcdm_arb_resp_fifo #(
    .Depth (RespDepth)
  ) i_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (inflight_q),
    .data_i  (pushData),
    .valid_o (bus.resp_valid_o),
    .pop_i   (bus.resp_ready_i),
    .data_o  (respData),
    .occ_o   (occ)
  );

  assign bus.resp_sel_o   = respData.sel;
  assign bus.resp_meta_o  = respData.meta;
  assign bus.resp_rdata_o = respData.rdata;

`ifdef TCDM_ARB_PERF_CNT_EN
  logic [PerfCntWidth-1:0] grantCnt_q, conflictCnt_q, stallCnt_q;
  logic                    conflict;
  logic                    stall;

  assign conflict = ($countones(bus.req_valid_i) >= 2);
  assign stall    = (|bus.req_valid_i) && !arbEn;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grantCnt_q    <= '0;
      conflictCnt_q <= '0;
      stallCnt_q    <= '0;
    end else begin
      if (grant && !(&grantCnt_q))       grantCnt_q    <= grantCnt_q + 1'b1;
      if (conflict && !(&conflictCnt_q)) conflictCnt_q <= conflictCnt_q + 1'b1;
      if (stall && !(&stallCnt_q))       stallCnt_q    <= stallCnt_q + 1'b1;
    end
  end

  assign bus.grant_cnt_o    = grantCnt_q;
  assign bus.conflict_cnt_o = conflictCnt_q;
  assign bus.stall_cnt_o    = stallCnt_q;
`else
  assign bus.grant_cnt_o    = '0;
  assign bus.conflict_cnt_o = '0;
  assign bus.stall_cnt_o    = '0;
`endif

endmodule

// File: doc/tcdm_bank_rr_arbiter.md
# tcdm_bank_rr_arbiter

Round-robin arbiter sharing one single-ported TCDM bank between `NumReq` requesters inside a tile. Grants at most one request per cycle, drives the bank directly, captures the fixed-latency bank response, and returns it with the original metadata and requester index. A credit scheme guarantees that every issued bank access has a free response slot, because the bank cannot be stalled.

## Interface
- `NumReq`, 4: requesters; ≥2.
- `AddrWidth`, 10: bank-local word address width.
- `DataWidth`, 32: data width; `DataWidth/8` strobe bits.
- `MetaWidth`, 16: opaque metadata carried request→response.
- `RespDepth`, 2: response FIFO depth = credits; ≥1.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `req_valid_i` in NumReq: per-requester request valid.
- `req_ready_o` out NumReq: per-requester grant/accept.
- `req_addr_i` in NumReq×AddrWidth: word address.
- `req_write_i` in NumReq: 1 = write.
- `req_wdata_i` in NumReq×DataWidth: write data.
- `req_be_i` in NumReq×DataWidth/8: byte enables.
- `req_meta_i` in NumReq×MetaWidth: metadata.
- `bank_req_o` out 1: bank access this cycle.
- `bank_we_o`, `bank_addr_o`, `bank_wdata_o`, `bank_be_o` out: the granted request's fields.
- `bank_rdata_i` in DataWidth: read data, valid exactly one cycle after `bank_req_o`.
- `resp_valid_o` out 1; `resp_ready_i` in 1: response handshake.
- `resp_sel_o` out $clog2(NumReq): destination requester.
- `resp_meta_o` out MetaWidth; `resp_rdata_o` out DataWidth: returned metadata and data (0 for writes).
- `grant_cnt_o`, `conflict_cnt_o`, `stall_cnt_o` out 32: performance counters (see Configuration).

## Operation
- Every accepted request, read or write, yields exactly one response, in grant order.
- Credits: `credits = RespDepth − fifo_occupancy − inflight`; `inflight` ∈ {0,1} is the access issued last cycle. Arbitration is enabled iff `credits > 0`, or `credits == 0` while a pop (`resp_valid_o && resp_ready_i`) occurs in the same cycle.
- Arbitration: round-robin pointer `rr_q` (reset 0). The winner is the first valid index at or after `rr_q`, searching cyclically. On a grant to i, `rr_q ← (i+1) mod NumReq`. Without a grant, `rr_q` holds.
- Only the winner sees `req_ready_o` = 1, and only when arbitration is enabled. A grant is combinational on `req_valid_i`. `bank_req_o` = 1 in the same cycle with the winner's fields; all bank outputs are 0 otherwise.
- Pipeline register (cycle t): `inflight`, winner index, meta, write flag. In t+1, push {sel, meta, write ? 0 : `bank_rdata_i`} into the FIFO.
- FIFO is fall-through: a push in t+1 with an empty FIFO gives `resp_valid_o` = 1 in t+1. Push and pop in the same cycle are allowed at any occupancy.
- While `resp_valid_o && !resp_ready_i`, response outputs stay stable.
- Requesters must hold valid and fields until ready; a dropped valid before ready is legal and simply not granted.

## Timing
- Request→response latency: 1 cycle minimum (grant t, `resp_valid_o` t+1), plus FIFO wait.
- Throughput: 1 request/cycle sustained when `resp_ready_i` = 1 and `RespDepth` ≥ 1.
- Reset values: `req_ready_o` 0, `bank_req_o` 0, bank fields 0, `resp_valid_o` 0, `resp_sel_o`/`resp_meta_o`/`resp_rdata_o` 0, counters 0, `rr_q` 0, FIFO empty, `inflight` 0.
- Reset mid-operation: an in-flight access and all buffered responses are discarded. No output is asserted until the first grant after release.
- Full: with `credits` = 0 and no pop, all `req_ready_o` = 0. The pop-same-cycle case grants with no bubble.
- Wrap-around: `rr_q` from NumReq−1 goes to 0.

## Configuration
- `TCDM_ARB_PERF_CNT_EN` defined: 32-bit saturating counters.
  - `grant_cnt_o` increments per grant.
  - `conflict_cnt_o` increments per cycle with ≥2 `req_valid_i` set.
  - `stall_cnt_o` increments per cycle with any valid request but arbitration disabled by credits.
- Undefined: ports remain, tied to 0; no counter flops are synthesised.

## Structure
- Shared package `tcdm_arb_pkg`:
  - `arb_resp_t` struct {sel, meta, rdata}.
  - `sel_req_t` type.
  - `PerfCntWidth = 32`.
- One sub-module, `tcdm_arb_resp_fifo`: parameterised fall-through FIFO of `arb_resp_t` with occupancy output, used for the response buffer. Arbitration, credits and the pipeline register stay in the top.

## Test plan
- Single read: req0 reads addr 0x05 (bank returns 0xDEADBEEF), meta 0x1234 → `req_ready_o[0]` in t, `resp_valid_o` t+1 with sel 0, meta 0x1234, rdata 0xDEADBEEF.
- All 4 requesters valid continuously, `resp_ready_i` = 1 → grants in order 0,1,2,3,0… one per cycle; responses in the same order with matching meta.
- `resp_ready_i` = 0, RespDepth 2, req0 valid → exactly 2 grants, then ready stays 0. Raising `resp_ready_i` grants again in the same cycle as the pop.
- Write, be 4'b0011, wdata 0xA5A5A5A5 → `bank_we_o` = 1 with those fields; response rdata 0.
- Reset asserted with 1 in flight and 1 buffered → after release `resp_valid_o` = 0 and `rr_q` = 0 (req3 and req0 valid → req0 wins).
- With `TCDM_ARB_PERF_CNT_EN`: 10 cycles of 2 valid requesters and ready = 1 → `grant_cnt_o` 10, `conflict_cnt_o` 10, `stall_cnt_o` 0.
